// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC datapath: fine-stage latency, width helper,
// 3-input majority vote and the fine-result record used by the timestamp assembler.
package tdc_pkg;

  // Clock edges from a sample strobe to a result candidate at the output register.
  localparam int TDC_FINE_LAT = 4;

  // Widest fine count any legal build produces (TAPS=256 needs 0..256).
  localparam int TDC_FINE_CW_MAX = 9;

  typedef struct packed {
    logic [TDC_FINE_CW_MAX-1:0] count;
    logic                       underflow;
    logic                       overflow;
    logic                       bubble;
  } tdc_fine_res_t;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/SB_CARRY.sv
// Behavioural model of the iCE40 SB_CARRY cell for simulation and lint.
// FPGA builds take the cell from the vendor library instead of this file.
module SB_CARRY (
  output logic CO,
  input  logic I0,
  input  logic I1,
  input  logic CI
);

  assign CO = (I0 & I1) | ((I0 | I1) & CI);

endmodule

// File: rtl/tdc_carry_chain.sv
// TAPS-long delay line built from SB_CARRY cells. With I0=0 and I1=1 each cell
// simply forwards CI to CO, so the hit edge ripples along the dedicated carry path.
module tdc_carry_chain #(
  parameter int TAPS = 64
) (
  input  logic            signal_in,
  output logic [TAPS-1:0] taps
);

  logic [TAPS:0] carry;

  assign carry[0] = signal_in;

  // One carry cell per tap; tap i is the CO of stage i.
  for (genvar i = 0; i < TAPS; i++) begin : g_stage
    SB_CARRY u_carry (
      .CO (carry[i+1]),
      .I0 (1'b0),
      .I1 (1'b1),
      .CI (carry[i])
    );
  end

  assign taps = carry[TAPS:1];

endmodule

// File: rtl/tdc_fine_encoder.sv
// Fine-time encoder: capture taps, synchronise, normalise polarity, remove
// thermometer bubbles, pipelined popcount, single-entry output register.
//
// Output handshake: a result is transferred on any rising clk edge where
// out_valid && out_ready. out_valid, once set, stays high with stable data until
// that transfer. The pipeline itself is never stalled: a candidate arriving while
// an untransferred result is held (out_valid && !out_ready) is dropped and sets
// the sticky overrun flag. TAPS must be a multiple of 8 in the range 8..256.
module tdc_fine_encoder
  import tdc_pkg::*;
#(
  parameter int TAPS     = 64,
  parameter int EXT_TAPS = 0,
  parameter int CW       = clog2(TAPS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            signal_in,
  input  logic [TAPS-1:0] tap_in,
  input  logic            sample,
  input  logic            edge_fall,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   fine_count,
  output logic            underflow,
  output logic            overflow,
  output logic            bubble,
  output logic            overrun,
  input  logic            overrun_clr
);

  localparam int NBYTES = TAPS / 8;

  logic [TAPS-1:0] taps;

  // Tap source: external bus for calibration/bench, otherwise the carry chain.
  if (EXT_TAPS != 0) begin : g_ext
    logic unused_signal_in;
    assign taps             = tap_in;
    assign unused_signal_in = signal_in;
  end else begin : g_chain
    logic unused_tap_in;
    tdc_carry_chain #(.TAPS(TAPS)) u_chain (
      .signal_in (signal_in),
      .taps      (taps)
    );
    assign unused_tap_in = ^tap_in;
  end

  logic                   v0, v1, v2, v3;
  logic                   pol0, pol1;
  logic                   bub2, bub3;
  logic [TAPS-1:0]        cap, syn, corr;
  logic [TAPS-1:0]        norm, corr_next;
  logic [TAPS+1:0]        ext;
  logic [NBYTES-1:0][3:0] psum, psum_next;
  logic [CW-1:0]          cand;

  // Stage valids: a sample strobe walks S0..S3; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v0 <= sample;
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Normalise to "ones below the edge" and vote each bit with its neighbours.
  // The line is padded with a 1 below tap 0 and a 0 above the top tap.
  always_comb begin
    norm      = syn ^ {TAPS{pol1}};
    ext       = {1'b0, norm, 1'b1};
    corr_next = '0;
    for (int i = 0; i < TAPS; i++) begin
      corr_next[i] = majority3(ext[i], ext[i+1], ext[i+2]);
    end
  end

  // Per-byte popcount of the corrected code.
  always_comb begin
    psum_next = '0;
    for (int b = 0; b < NBYTES; b++) begin
      for (int k = 0; k < 8; k++) begin
        psum_next[b] = psum_next[b] + {3'b000, corr[8*b+k]};
      end
    end
  end

  // Final sum; CW holds 0..TAPS so the full-scale count cannot wrap.
  always_comb begin
    cand = '0;
    for (int b = 0; b < NBYTES; b++) begin
      cand = cand + CW'(psum[b]);
    end
  end

  // Pipeline data: capture, metastability flop, corrected code, partial sums.
  always_ff @(posedge clk) begin
    if (sample) begin
      cap  <= taps;
      pol0 <= edge_fall;
    end
    syn  <= cap;
    pol1 <= pol0;
    corr <= corr_next;
    bub2 <= |(corr_next ^ norm);
    psum <= psum_next;
    bub3 <= bub2;
  end

  // Output register: load when free or being drained, else drop and flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      fine_count <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
      bubble     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (v3) begin
        if (!out_valid || out_ready) begin
          out_valid  <= 1'b1;
          fine_count <= cand;
          underflow  <= (cand == '0);
          overflow   <= (cand == CW'(TAPS));
          bubble     <= bub3;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (v3 && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
